// File: rtl/tft_video_decoder.sv
// tft_video_decoder: recovers pixel coordinates, frame strobes, frame count and lock from TFT den/hsync/vsync timing.
// Define TFT_DEC_CHECK_EN to enable line/frame length checking and the sticky err flag.
module tft_video_decoder #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int VBLANK_MIN = 8,
  parameter int XW         = 11,
  parameter int YW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          den,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [7:0]    R,
  input  logic [7:0]    G,
  input  logic [7:0]    B,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [23:0]   pix_rgb,
  output logic          sof,
  output logic          eol,
  output logic          locked,
  output logic [15:0]   frame_cnt,
  output logic          err
);
  localparam int IW = $clog2(VBLANK_MIN + 1);
  localparam logic [1:0] HUNT = 2'd0, WAIT = 2'd1, ACTIVE = 2'd2;
  localparam logic [XW-1:0] HA   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HMAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] VMAX = YW'(V_ACTIVE - 1);
  localparam logic [IW-1:0] IMAX = IW'(VBLANK_MIN);

  logic          den_q, den_qq, hs_q, hs_qq, vs_q, vs_qq;
  logic [23:0]   rgb_q;
  logic [1:0]    st, st_n;
  logic [IW-1:0] idle_lines;
  logic          line_den, vs_seen;
  logic [XW-1:0] cnt, x_n;
  logic          rise, hs_fall, vs_fall, blank, act, fs, fend, ovr, valid_n, lock_ok;

  assign rise    = den_q & ~den_qq;
  assign hs_fall = ~hs_q & hs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign blank   = idle_lines == IMAX;
  assign act     = st == ACTIVE;
  assign fs      = rise & (blank | vs_seen | vs_fall);
  assign fend    = act & (blank | fs);
  assign ovr     = act & rise & ~fs & (pix_y == VMAX);
  assign st_n    = fs ? ACTIVE : ovr ? HUNT : (fend | (st == HUNT & (blank | vs_fall))) ? WAIT : st;
  // cnt is the number of den-high cycles seen in the current run, saturating at H_ACTIVE
  assign valid_n = den_q & (st_n == ACTIVE) & (rise | cnt < HA);
  assign x_n     = rise ? '0 : (den_q & cnt < HA) ? cnt : pix_x;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {den_q, den_qq, hs_q, hs_qq, vs_q, vs_qq} <= '0;
      rgb_q      <= '0;
      st         <= HUNT;
      idle_lines <= '0;
      line_den   <= 1'b0;
      vs_seen    <= 1'b0;
      cnt        <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      locked     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      {den_qq, hs_qq, vs_qq} <= {den_q, hs_q, vs_q};
      {den_q, hs_q, vs_q}    <= {den, hsync, vsync};
      rgb_q      <= {R, G, B};
      st         <= st_n;
      idle_lines <= den_q ? '0 : (hs_fall & ~line_den & ~blank) ? idle_lines + 1'b1 : idle_lines;
      line_den   <= hs_fall ? den_q : line_den | den_q;
      vs_seen    <= den_q ? 1'b0 : vs_seen | vs_fall;
      cnt        <= rise ? XW'(1) : (den_q & cnt < HA) ? cnt + 1'b1 : cnt;
      pix_valid  <= valid_n;
      pix_x      <= x_n;
      pix_y      <= fs ? '0 : (act & rise & ~ovr) ? pix_y + 1'b1 : pix_y;
      pix_rgb    <= rgb_q;
      sof        <= fs;
      eol        <= valid_n & (x_n == HMAX);
      locked     <= ovr ? 1'b0 : fend ? lock_ok : locked;
      frame_cnt  <= frame_cnt + {15'd0, fs};
    end

`ifdef TFT_DEC_CHECK_EN
  logic bad, prot;
  // protocol faults only matter while a frame is being tracked
  assign prot    = (act | fs) & ((~den_q & den_qq & cnt < HA) | (den_q & ~rise & cnt >= HA) | (rise & ~hs_q));
  assign lock_ok = ~bad & (pix_y == VMAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bad <= 1'b0;
      err <= 1'b0;
    end else begin
      bad <= fs ? prot : bad | prot;
      err <= err | prot | ovr | (fend & ~lock_ok);
    end
`else
  assign lock_ok = 1'b1;
  assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_tft_video_decoder.sv
// tb_tft_video_decoder: line-level reference model driving randomized pixel data through tft_video_decoder.
module tb_tft_video_decoder;
  localparam int H = 8, V = 4, VB = 2, XW = 4, YW = 3;
`ifdef TFT_DEC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 0, rst = 0, den = 0, hsync = 1, vsync = 1;
  logic [7:0] R = 0, G = 0, B = 0;
  logic pix_valid, sof, eol, locked, err;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [23:0] pix_rgb;
  logic [15:0] frame_cnt;
  int vectors = 0, miscompares = 0;
  int lens[8] = '{0, 0, 8, 8, 8, 8, 6, 10};

  typedef struct {int x; int y; logic [23:0] rgb; bit sof; bit eol;} pix_t;
  pix_t expq[$];

  bit m_hunting, m_inframe, m_vs_seen, m_bad, m_prev_den, m_locked, m_err;
  int m_idle, m_y, m_fcnt;

  always #5 clk = ~clk;

  tft_video_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_MIN(VB), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .den(den), .hsync(hsync), .vsync(vsync), .R(R), .G(G), .B(B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .sof(sof), .eol(eol),
    .locked(locked), .frame_cnt(frame_cnt), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hunting = 1; m_inframe = 0; m_vs_seen = 0; m_bad = 0; m_prev_den = 0;
    m_locked = 0; m_err = 0; m_idle = 0; m_y = 0; m_fcnt = 0;
    expq.delete();
  endtask

  task automatic frame_end();
    if (CHK) begin
      if (m_bad || m_y != V - 1) m_err = 1;
      m_locked = !m_bad && m_y == V - 1;
    end else m_locked = 1;
    m_inframe = 0;
  endtask

  task automatic monitor();
    pix_t e;
    if (pix_valid) begin
      if (expq.size() == 0) chk("spurious_valid", pix_valid, 0);
      else begin
        e = expq.pop_front();
        chk("pix_x", pix_x, e.x);
        chk("pix_y", pix_y, e.y);
        chk("pix_rgb", pix_rgb, e.rgb);
        chk("sof", sof, e.sof);
        chk("eol", eol, e.eol);
      end
    end else begin
      chk("sof_idle", sof, 0);
      chk("eol_idle", eol, 0);
    end
  endtask

  // One 16-clock line: hsync low at 0..1, den from clock 4 for len clocks, optional vsync at 4..5.
  task automatic send_line(input int len, input bit vs, input int rst_at);
    logic [23:0] px[16];
    pix_t e;
    bit fs;
    for (int i = 0; i < 16; i++) px[i] = 24'($urandom);
    if (!m_prev_den && m_idle < VB) m_idle++;
    m_prev_den = 0;
    if (m_idle == VB) begin
      if (m_inframe) frame_end();
      m_hunting = 0;
    end
    if (vs && len == 0) begin m_vs_seen = 1; m_hunting = 0; end
    if (len > 0) begin
      fs = (m_idle == VB) || m_vs_seen || vs;
      if (fs) begin
        if (m_inframe) frame_end();
        m_inframe = 1; m_hunting = 0; m_y = 0; m_bad = 0; m_fcnt = (m_fcnt + 1) % 65536;
      end else if (m_inframe) begin
        if (m_y == V - 1) begin
          m_inframe = 0; m_hunting = 1; m_locked = 0;
          if (CHK) m_err = 1;
        end else m_y++;
      end
      m_idle = 0; m_vs_seen = 0; m_prev_den = 1;
      if (m_inframe) begin
        for (int i = 0; i < len && i < H; i++) begin
          e.x = i; e.y = m_y; e.rgb = px[i]; e.sof = fs && i == 0; e.eol = i == H - 1;
          expq.push_back(e);
        end
        if (len != H) begin m_bad = 1; if (CHK) m_err = 1; end
      end
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      monitor();
      hsync = c >= 2;
      den = c >= 4 && c < 4 + len;
      vsync = !(vs && (c == 4 || c == 5));
      {R, G, B} = den ? px[c-4] : 24'($urandom);
      if (c == rst_at) begin
        #2 rst = 0;
        #1 chk("async_reset_outs", {pix_valid, pix_x, pix_y, pix_rgb, sof, eol, locked, frame_cnt, err}, 0);
        model_reset();
      end
      if (rst_at >= 0 && c == rst_at + 5) rst = 1;
    end
    chk("locked", locked, m_locked);
    chk("frame_cnt", frame_cnt, m_fcnt);
    chk("err", err, m_err);
    chk("pending_pixels", expq.size(), 0);
  endtask

  task automatic send_frame(input int bad_line, input int bad_len);
    for (int l = 0; l < V; l++) send_line(l == bad_line ? bad_len : H, 0, -1);
    for (int l = 0; l < 4; l++) send_line(0, 0, -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; den = 0; hsync = 1; vsync = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outs", {pix_valid, pix_x, pix_y, pix_rgb, sof, eol, locked, frame_cnt, err}, 0);
    rst = 1;
  endtask

  initial begin
    do_reset();
    send_line(0, 0, -1);
    send_line(0, 0, -1);
    repeat (3) send_frame(-1, H);
    chk("three_frames_cnt", frame_cnt, 3);
    chk("three_frames_locked", locked, 1);
    send_frame(2, 6);
    chk("short_line_locked", locked, CHK ? 0 : 1);
    chk("short_line_err", err, CHK);
    send_frame(-1, H);
    chk("relock_after_short", locked, 1);
    chk("err_sticky", err, CHK);
    send_frame(1, 10);
    chk("long_line_err", err, CHK);
    send_frame(-1, H);
    repeat (5) send_line(H, 0, -1);
    chk("overrun_locked", locked, 0);
    send_line(0, 0, -1);
    send_line(0, 0, -1);
    send_frame(-1, H);
    chk("resync_locked", locked, 1);
    send_line(H, 0, -1);
    send_line(H, 0, -1);
    send_line(H, 0, 7);
    send_line(H, 0, -1);
    for (int l = 0; l < 4; l++) send_line(0, 0, -1);
    send_frame(-1, H);
    chk("post_reset_fcnt", frame_cnt, 1);
    do_reset();
    send_line(H, 1, -1);
    chk("vsync_start_fcnt", frame_cnt, 1);
    for (int l = 1; l < V; l++) send_line(H, 0, -1);
    for (int l = 0; l < 4; l++) send_line(0, 0, -1);
    chk("vsync_frame_locked", locked, 1);
    repeat (60) begin
      int len;
      len = lens[$urandom_range(0, 7)];
      send_line(len, len == 0 && $urandom_range(0, 3) == 0, -1);
    end
    for (int l = 0; l < 4; l++) send_line(0, 0, -1);
    send_frame(-1, H);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
